// File: rtl/freq_meter.sv
// Gated frequency/period meter: counts sig_in rising edges over GATE_CYCLES clocks and
// reports the spacing of the last two edges; results load in a one-cycle DONE state.
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 50000000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             en,
  output logic [CNT_W-1:0] freq_count,
  output logic [CNT_W-1:0] period_count,
  output logic             ovf,
  output logic             valid,
  output logic             busy
);

  localparam int unsigned      GW        = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {S_IDLE, S_GATE, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q, hist_q;
  logic             rise;
  logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] per_run_q, per_run_d;
  logic [CNT_W-1:0] per_last_q, per_last_d;
  logic             seen_edge_q, seen_edge_d;
  logic             two_edges_q, two_edges_d;
  logic             ovf_int_q, ovf_int_d;
  logic [CNT_W-1:0] freq_count_q, freq_count_d;
  logic [CNT_W-1:0] period_count_q, period_count_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Abort on en low wins over window completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (en) state_d = S_GATE;
      S_GATE: begin
        if (!en)                          state_d = S_IDLE;
        else if (gate_cnt_q == GATE_LAST) state_d = S_DONE;
      end
      S_DONE: state_d = en ? S_GATE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    gate_cnt_d     = '0;
    edge_cnt_d     = '0;
    per_run_d      = '0;
    per_last_d     = '0;
    seen_edge_d    = 1'b0;
    two_edges_d    = 1'b0;
    ovf_int_d      = 1'b0;
    freq_count_d   = freq_count_q;
    period_count_d = period_count_q;
    ovf_d          = ovf_q;
    valid_d        = 1'b0;
    busy_d         = (state_d != S_IDLE);
    if (state_q == S_GATE) begin
      gate_cnt_d  = gate_cnt_q + GW'(1);
      edge_cnt_d  = edge_cnt_q;
      per_run_d   = per_run_q;
      per_last_d  = per_last_q;
      seen_edge_d = seen_edge_q;
      two_edges_d = two_edges_q;
      ovf_int_d   = ovf_int_q;
      if (seen_edge_q) begin
        if (per_run_q == CNT_MAX) ovf_int_d = 1'b1;
        else                      per_run_d = per_run_q + CNT_W'(1);
      end
      if (rise) begin
        if (edge_cnt_q == CNT_MAX) ovf_int_d  = 1'b1;
        else                       edge_cnt_d = edge_cnt_q + CNT_W'(1);
        if (seen_edge_q) begin
          per_last_d  = per_run_q;
          two_edges_d = 1'b1;
        end
        // One clock has elapsed by the time the next cycle samples per_run.
        per_run_d   = CNT_W'(1);
        seen_edge_d = 1'b1;
      end
      // Results are registered on entry to DONE so they appear with valid.
      if (state_d == S_DONE) begin
        freq_count_d   = edge_cnt_d;
        period_count_d = two_edges_d ? per_last_d : '0;
        ovf_d          = ovf_int_d;
        valid_d        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate_cnt_q     <= '0;
      edge_cnt_q     <= '0;
      per_run_q      <= '0;
      per_last_q     <= '0;
      seen_edge_q    <= 1'b0;
      two_edges_q    <= 1'b0;
      ovf_int_q      <= 1'b0;
      freq_count_q   <= '0;
      period_count_q <= '0;
      ovf_q          <= 1'b0;
      valid_q        <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      gate_cnt_q     <= gate_cnt_d;
      edge_cnt_q     <= edge_cnt_d;
      per_run_q      <= per_run_d;
      per_last_q     <= per_last_d;
      seen_edge_q    <= seen_edge_d;
      two_edges_q    <= two_edges_d;
      ovf_int_q      <= ovf_int_d;
      freq_count_q   <= freq_count_d;
      period_count_q <= period_count_d;
      ovf_q          <= ovf_d;
      valid_q        <= valid_d;
      busy_q         <= busy_d;
    end
  end

  assign freq_count   = freq_count_q;
  assign period_count = period_count_q;
  assign ovf          = ovf_q;
  assign valid        = valid_q;
  assign busy         = busy_q;

endmodule
